assoc_miss_handler: RTL and testbench

//  Request front-end placed directly upstream of the 8x4-bit associative memory (CAM).

---
 rtl/assoc_pkg.sv | 18 +
 rtl/amh_sat_counter.sv | 21 ++
 rtl/assoc_miss_handler.sv | 163 ++++++++++++++++
 tb/tb_assoc_miss_handler.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_pkg.sv
// Shared types and sizing for the CAM miss handler.
package assoc_pkg;

    localparam int AMH_ADDR_W = 4;
    localparam int AMH_DATA_W = 4;
    localparam int AMH_TMO_W  = 8;
    localparam int AMH_STAT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        FILL,
        RESP
    } amh_state_t;

endpackage

// File: rtl/amh_sat_counter.sv
// Event counter that sticks at its maximum value; clr has priority over inc.
module amh_sat_counter
    import assoc_pkg::*;
#(
    parameter int W = AMH_STAT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/assoc_miss_handler.sv
// Read front-end for the 8x4 CAM: hits return CAM data, misses fetch from the backing store and fill.
// Define ASSOC_STATS_EN to add saturating hit/miss/timeout counters (hit_cnt, miss_cnt, err_cnt).
module assoc_miss_handler
    import assoc_pkg::*;
#(
    parameter int ADDR_W      = AMH_ADDR_W,
    parameter int DATA_W      = AMH_DATA_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_hit,
    output logic                  rsp_err,
    output logic                  cam_wr,
    output logic [ADDR_W-1:0]     cam_addr,
    output logic [DATA_W-1:0]     cam_din,
    input  logic [DATA_W-1:0]     cam_dout,
    input  logic                  cam_hit,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_data
`ifdef ASSOC_STATS_EN
    ,
    output logic [AMH_STAT_W-1:0] hit_cnt,
    output logic [AMH_STAT_W-1:0] miss_cnt,
    output logic [AMH_STAT_W-1:0] err_cnt
`endif
);

    // Counter value in the last MEM_REQ cycle before giving up.
    localparam logic [AMH_TMO_W-1:0] TMO_LAST = AMH_TMO_W'(MEM_TIMEOUT - 1);

    amh_state_t           state;
    amh_state_t           next_state;
    logic [AMH_TMO_W-1:0] tmo_cnt;
    logic                 accept;
    logic                 check_hit;
    logic                 timeout;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        check_hit  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    next_state = LOOKUP;
                end
            end
            LOOKUP: next_state = CHECK;
            CHECK: begin
                // An unknown hit flag from the CAM is treated as a miss.
                check_hit  = (cam_hit === 1'b1);
                next_state = check_hit ? RESP : MEM_REQ;
            end
            MEM_REQ: begin
                if (mem_ack) begin
                    next_state = FILL;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            FILL: next_state = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake and strobe outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 1'b0;
            cam_wr    <= 1'b0;
            cam_addr  <= '0;
            cam_din   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            tmo_cnt   <= '0;
        end else begin
            req_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            cam_wr    <= (next_state == FILL);
            mem_req   <= (next_state == MEM_REQ);
            tmo_cnt   <= (state == MEM_REQ) ? tmo_cnt + 1'b1 : '0;
            if (accept) begin
                cam_addr <= req_addr;
                mem_addr <= req_addr;
            end
            if (check_hit) begin
                rsp_data <= cam_dout;
                rsp_hit  <= 1'b1;
                rsp_err  <= 1'b0;
            end
            if ((state == MEM_REQ) && mem_ack) begin
                cam_din <= mem_data;
            end
            if (timeout) begin
                rsp_data <= '0;
                rsp_hit  <= 1'b0;
                rsp_err  <= 1'b1;
            end
            // cam_din still holds the fetched word, so it doubles as the response data.
            if (state == FILL) begin
                rsp_data <= cam_din;
                rsp_hit  <= 1'b0;
                rsp_err  <= 1'b0;
            end
        end
    end

`ifdef ASSOC_STATS_EN
    logic check_miss;
    assign check_miss = (state == CHECK) && !check_hit;

    amh_sat_counter #(.W(AMH_STAT_W)) u_hit_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (check_hit),
        .count (hit_cnt)
    );

    amh_sat_counter #(.W(AMH_STAT_W)) u_miss_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (check_miss),
        .count (miss_cnt)
    );

    amh_sat_counter #(.W(AMH_STAT_W)) u_err_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (timeout),
        .count (err_cnt)
    );
`endif

endmodule

// File: tb/tb_assoc_miss_handler.sv
// Bench for assoc_miss_handler: CAM and backing-store models plus a request-level reference model.
module tb_assoc_miss_handler;

    localparam int MEM_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_addr = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_hit;
    logic       rsp_err;
    logic       cam_wr;
    logic [3:0] cam_addr;
    logic [3:0] cam_din;
    logic [3:0] cam_dout = '0;
    logic       cam_hit = 1'b0;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [3:0] mem_data = '0;
`ifdef ASSOC_STATS_EN
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    assoc_miss_handler #(
        .ADDR_W      (4),
        .DATA_W      (4),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_hit   (rsp_hit),
        .rsp_err   (rsp_err),
        .cam_wr    (cam_wr),
        .cam_addr  (cam_addr),
        .cam_din   (cam_din),
        .cam_dout  (cam_dout),
        .cam_hit   (cam_hit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
`ifdef ASSOC_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    logic [21:0] all_outs;
    assign all_outs = {req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err, cam_wr,
                       cam_addr, cam_din, mem_req, mem_addr};

    typedef struct {
        logic [3:0] data;
        logic       hit;
        logic       err;
        int         memreq;
        int         camwr;
    } exp_t;

    typedef struct {
        logic [3:0] data;
        logic       hit;
        logic       err;
        int         lat;
        bit         stable;
        logic       post_valid;
        logic       post_ready;
        int         memreq;
        int         camwr;
        logic [3:0] wr_addr;
        logic [3:0] wr_din;
    } obs_t;

    int         checks = 0;
    int         fails = 0;
    logic [3:0] store [16];
    int         ack_delay = 0;
    bit         ack_never = 1'b0;
    int         memreq_cycles = 0;
    int         camwr_cycles = 0;
    logic [3:0] wr_addr_seen = '0;
    logic [3:0] wr_din_seen = '0;

    // Reference model: which addresses the CAM holds (oldest evicted first) and event counts.
    logic [3:0] ref_cached[$];
    int         ref_hits = 0;
    int         ref_miss = 0;
    int         ref_err = 0;

    function automatic bit ref_is_cached(input logic [3:0] a);
        foreach (ref_cached[i]) begin
            if (ref_cached[i] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t ref_predict(input logic [3:0] a, input int delay, input bit never);
        exp_t e;
        if (ref_is_cached(a)) begin
            e = '{data: store[a], hit: 1'b1, err: 1'b0, memreq: 0, camwr: 0};
            ref_hits++;
        end else begin
            ref_miss++;
            if (never || (delay >= MEM_TIMEOUT)) begin
                e = '{data: 4'h0, hit: 1'b0, err: 1'b1, memreq: MEM_TIMEOUT, camwr: 0};
                ref_err++;
            end else begin
                e = '{data: store[a], hit: 1'b0, err: 1'b0, memreq: delay + 1, camwr: 1};
                if (ref_cached.size() == 8) void'(ref_cached.pop_front());
                ref_cached.push_back(a);
            end
        end
        return e;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // 8-entry CAM: writes on cam_wr, otherwise a registered lookup of cam_addr.
    initial begin : cam_model
        logic [3:0] tag [8];
        logic [3:0] val [8];
        bit         vld [8];
        int         ptr;
        int         slot;
        ptr = 0;
        for (int i = 0; i < 8; i++) vld[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (cam_wr) begin
                slot = -1;
                for (int i = 0; i < 8; i++) if (vld[i] && tag[i] == cam_addr) slot = i;
                if (slot < 0) begin
                    slot = ptr;
                    ptr  = (ptr + 1) % 8;
                end
                tag[slot] = cam_addr;
                val[slot] = cam_din;
                vld[slot] = 1'b1;
            end else begin
                cam_hit  = 1'b0;
                cam_dout = 4'h0;
                for (int i = 0; i < 8; i++) begin
                    if (vld[i] && tag[i] == cam_addr) begin
                        cam_hit  = 1'b1;
                        cam_dout = val[i];
                    end
                end
            end
        end
    end

    // Backing store answers in MEM_REQ cycle number ack_delay (0 = first cycle).
    initial begin : mem_model
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!ack_never && k == ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = store[mem_addr];
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = 4'($urandom_range(0, 15));
                end
                k++;
            end else begin
                mem_ack = 1'b0;
                k       = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_req) memreq_cycles++;
            if (cam_wr) begin
                camwr_cycles++;
                wr_addr_seen = cam_addr;
                wr_din_seen  = cam_din;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues one request, holds rsp_ready low for 'hold' cycles, then completes the handshake.
    task automatic run_req(input logic [3:0] a, input int delay, input bit never,
                           input int hold, output obs_t o);
        int n;
        ack_delay = delay;
        ack_never = never;
        o.stable  = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL accept_wait: req_ready=%b after %0d cycles, want 1", req_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid     = 1'b0;
        req_addr      = 4'($urandom_range(0, 15));
        memreq_cycles = 0;
        camwr_cycles  = 0;
        o.lat = 0;
        while (!rsp_valid && o.lat < 100) begin
            @(negedge clk);
            o.lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rsp_wait: rsp_valid=%b after %0d cycles, want 1", rsp_valid, o.lat);
        end
        o.data = rsp_data;
        o.hit  = rsp_hit;
        o.err  = rsp_err;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== o.data || rsp_hit !== o.hit ||
                rsp_err !== o.err || req_ready !== 1'b0) o.stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready    = 1'b0;
        o.post_valid = rsp_valid;
        o.post_ready = req_ready;
        o.memreq     = memreq_cycles;
        o.camwr      = camwr_cycles;
        o.wr_addr    = wr_addr_seen;
        o.wr_din     = wr_din_seen;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== 22'h0) begin
            fails++;
            $display("[TB] FAIL reset_outs: got %h, want 0", all_outs);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b, want 1", req_ready);
        end
        checks++;
        if (all_outs[20:0] !== 21'h0) begin
            fails++;
            $display("[TB] FAIL reset_idle_outs: got %h, want 0", all_outs[20:0]);
        end
    endtask

    task automatic test_cold_miss();
        obs_t o;
        exp_t e;
        store[3] = 4'hA;
        e = ref_predict(4'h3, 2, 1'b0);
        run_req(4'h3, 2, 1'b0, 0, o);
        checks++; if (o.data !== e.data) begin fails++; $display("[TB] FAIL cold_data: got %h, want %h", o.data, e.data); end
        checks++; if (o.hit !== e.hit) begin fails++; $display("[TB] FAIL cold_hit: got %b, want %b", o.hit, e.hit); end
        checks++; if (o.err !== e.err) begin fails++; $display("[TB] FAIL cold_err: got %b, want %b", o.err, e.err); end
        checks++; if (o.camwr != e.camwr) begin fails++; $display("[TB] FAIL cold_camwr: got %0d, want %0d", o.camwr, e.camwr); end
        checks++; if (o.wr_addr !== 4'h3 || o.wr_din !== 4'hA) begin
            fails++; $display("[TB] FAIL cold_fill: got addr %h din %h, want 3 A", o.wr_addr, o.wr_din); end
        checks++; if (o.memreq != e.memreq) begin fails++; $display("[TB] FAIL cold_memreq: got %0d, want %0d", o.memreq, e.memreq); end
    endtask

    task automatic test_hit_after_fill();
        obs_t o;
        exp_t e;
        e = ref_predict(4'h3, 0, 1'b0);
        run_req(4'h3, 0, 1'b0, 0, o);
        checks++; if (o.memreq != 0) begin fails++; $display("[TB] FAIL hit_memreq: got %0d, want 0", o.memreq); end
        // rsp_valid is seen after the second edge following the accept edge (third cycle counting the accept cycle).
        checks++; if (o.lat != 2) begin fails++; $display("[TB] FAIL hit_latency: got %0d, want 2", o.lat); end
        checks++; if (o.data !== e.data || o.hit !== e.hit) begin
            fails++; $display("[TB] FAIL hit_resp: got data %h hit %b, want %h %b", o.data, o.hit, e.data, e.hit); end
        checks++; if (o.camwr != 0) begin fails++; $display("[TB] FAIL hit_camwr: got %0d, want 0", o.camwr); end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        e = ref_predict(4'h5, 0, 1'b1);
        run_req(4'h5, 0, 1'b1, 0, o);
        checks++; if (o.memreq != e.memreq) begin fails++; $display("[TB] FAIL tmo_memreq: got %0d, want %0d", o.memreq, e.memreq); end
        checks++; if (o.err !== 1'b1 || o.data !== 4'h0 || o.hit !== 1'b0) begin
            fails++; $display("[TB] FAIL tmo_resp: got err %b data %h hit %b, want 1 0 0", o.err, o.data, o.hit); end
        checks++; if (o.camwr != 0) begin fails++; $display("[TB] FAIL tmo_camwr: got %0d, want 0", o.camwr); end
    endtask

    task automatic test_ack_edges();
        obs_t o;
        exp_t e;
        e = ref_predict(4'h9, 0, 1'b0);
        run_req(4'h9, 0, 1'b0, 0, o);
        checks++; if (o.memreq != 1 || o.data !== e.data || o.err !== 1'b0) begin
            fails++; $display("[TB] FAIL ack_first: got memreq %0d data %h err %b, want 1 %h 0", o.memreq, o.data, o.err, e.data); end
        // Ack in the final allowed cycle must beat the timeout.
        e = ref_predict(4'hB, MEM_TIMEOUT - 1, 1'b0);
        run_req(4'hB, MEM_TIMEOUT - 1, 1'b0, 0, o);
        checks++; if (o.err !== 1'b0 || o.data !== e.data || o.camwr != 1) begin
            fails++; $display("[TB] FAIL ack_at_timeout: got err %b data %h camwr %0d, want 0 %h 1", o.err, o.data, o.camwr, e.data); end
        checks++; if (o.memreq != MEM_TIMEOUT) begin
            fails++; $display("[TB] FAIL ack_at_timeout_memreq: got %0d, want %0d", o.memreq, MEM_TIMEOUT); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        e = ref_predict(4'h3, 0, 1'b0);
        run_req(4'h3, 0, 1'b0, 5, o);
        checks++; if (o.stable !== 1'b1) begin fails++; $display("[TB] FAIL bp_stable: got %b, want 1", o.stable); end
        checks++; if (o.data !== e.data) begin fails++; $display("[TB] FAIL bp_data: got %h, want %h", o.data, e.data); end
        checks++; if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL bp_after: got valid %b ready %b, want 0 1", o.post_valid, o.post_ready); end
    endtask

    task automatic test_reset_mid_fetch();
        obs_t o;
        exp_t e;
        int   n;
        ack_never = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 4'h7;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        camwr_cycles = 0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (mem_req !== 1'b1) begin fails++; $display("[TB] FAIL rmf_fetch: mem_req=%b, want 1", mem_req); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (all_outs !== 22'h0) begin fails++; $display("[TB] FAIL rmf_outs: got %h, want 0", all_outs); end
        checks++; if (camwr_cycles != 0) begin fails++; $display("[TB] FAIL rmf_camwr: got %0d, want 0", camwr_cycles); end
        rst_n    = 1'b1;
        ref_hits = 0;
        ref_miss = 0;
        ref_err  = 0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
            fails++; $display("[TB] FAIL rmf_idle: got ready %b mem_req %b, want 1 0", req_ready, mem_req); end
`ifdef ASSOC_STATS_EN
        checks++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || err_cnt !== 8'd0) begin
            fails++; $display("[TB] FAIL rmf_stats: got %0d %0d %0d, want 0 0 0", hit_cnt, miss_cnt, err_cnt); end
`endif
        e = ref_predict(4'h7, 1, 1'b0);
        run_req(4'h7, 1, 1'b0, 0, o);
        checks++; if (o.hit !== e.hit || o.data !== e.data || o.camwr != e.camwr) begin
            fails++; $display("[TB] FAIL rmf_refetch: got hit %b data %h camwr %0d, want %b %h %0d",
                              o.hit, o.data, o.camwr, e.hit, e.data, e.camwr); end
    endtask

    task automatic test_random();
        obs_t       o;
        exp_t       e;
        logic [3:0] a;
        int         d;
        bit         nv;
        int         h;
        for (int i = 0; i < 40; i++) begin
            a  = 4'($urandom_range(0, 15));
            nv = ($urandom_range(0, 9) == 0);
            d  = $urandom_range(0, 5);
            h  = $urandom_range(0, 3);
            e  = ref_predict(a, d, nv);
            run_req(a, d, nv, h, o);
            checks++; if (o.data !== e.data || o.hit !== e.hit || o.err !== e.err) begin
                fails++; $display("[TB] FAIL rand_resp[%0d] addr %h: got %h/%b/%b, want %h/%b/%b",
                                  i, a, o.data, o.hit, o.err, e.data, e.hit, e.err); end
            checks++; if (o.memreq != e.memreq || o.camwr != e.camwr) begin
                fails++; $display("[TB] FAIL rand_bus[%0d] addr %h: got memreq %0d camwr %0d, want %0d %0d",
                                  i, a, o.memreq, o.camwr, e.memreq, e.camwr); end
            checks++; if (o.stable !== 1'b1 || o.post_ready !== 1'b1 || o.post_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL rand_hs[%0d]: got stable %b ready %b valid %b, want 1 1 0",
                                  i, o.stable, o.post_ready, o.post_valid); end
        end
    endtask

`ifdef ASSOC_STATS_EN
    task automatic test_stats();
        obs_t       o;
        exp_t       e;
        logic [3:0] a;
        checks++; if (hit_cnt !== 8'(sat255(ref_hits)) || miss_cnt !== 8'(sat255(ref_miss)) ||
                      err_cnt !== 8'(sat255(ref_err))) begin
            fails++; $display("[TB] FAIL stats_pre: got %0d %0d %0d, want %0d %0d %0d",
                              hit_cnt, miss_cnt, err_cnt, sat255(ref_hits), sat255(ref_miss), sat255(ref_err)); end
        a = ref_cached[ref_cached.size() - 1];
        for (int i = 0; i < 300; i++) begin
            e = ref_predict(a, 0, 1'b0);
            run_req(a, 0, 1'b0, 0, o);
        end
        checks++; if (hit_cnt !== 8'd255) begin fails++; $display("[TB] FAIL stats_hit_sat: got %0d, want 255", hit_cnt); end
        checks++; if (miss_cnt !== 8'(sat255(ref_miss))) begin
            fails++; $display("[TB] FAIL stats_miss: got %0d, want %0d", miss_cnt, sat255(ref_miss)); end
        checks++; if (err_cnt !== 8'(sat255(ref_err))) begin
            fails++; $display("[TB] FAIL stats_err: got %0d, want %0d", err_cnt, sat255(ref_err)); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) store[i] = 4'($urandom_range(0, 15));
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_timeout();
        test_ack_edges();
        test_backpressure();
        test_reset_mid_fetch();
        test_random();
`ifdef ASSOC_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
